// File: rtl/arc4_pkg.sv
// Shared ARC4 types: byte-wide datapath, prga state encoding and memory depth.
package arc4_pkg;

    localparam int unsigned MEM_DEPTH = 256;
    localparam int unsigned ADDR_W    = $clog2(MEM_DEPTH);

    typedef logic [ADDR_W-1:0] byte_t;

    typedef enum logic [3:0] {
        StIdle,
        StRdLen,
        StWrLen,
        StRdSi,
        StRdSj,
        StSwapI,
        StSwapJ,
        StRdPad,
        StWrPt
    } prga_state_t;

endpackage

// File: rtl/prga.sv
// ARC4 keystream generation and decrypt: reads length-prefixed ciphertext, permutes S in place,
// writes length-prefixed plaintext. Memories have one cycle of synchronous read latency.
module prga
    import arc4_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    output logic       rdy,
    output logic [7:0] s_addr,
    input  logic [7:0] s_rddata,
    output logic [7:0] s_wrdata,
    output logic       s_wren,
    output logic [7:0] ct_addr,
    input  logic [7:0] ct_rddata,
    output logic [7:0] pt_addr,
    output logic [7:0] pt_wrdata,
    output logic       pt_wren
);

    prga_state_t state_q, state_d;
    byte_t       i_q, i_d;
    byte_t       j_q, j_d;
    byte_t       k_q, k_d;
    byte_t       len_q, len_d;
    byte_t       si_q, si_d;
    byte_t       sj_q, sj_d;
    byte_t       jn;

    always_comb begin
        state_d   = state_q;
        i_d       = i_q;
        j_d       = j_q;
        k_d       = k_q;
        len_d     = len_q;
        si_d      = si_q;
        sj_d      = sj_q;
        jn        = '0;
        rdy       = 1'b0;
        s_addr    = '0;
        s_wrdata  = '0;
        s_wren    = 1'b0;
        ct_addr   = '0;
        pt_addr   = '0;
        pt_wrdata = '0;
        pt_wren   = 1'b0;

        case (state_q)
            StIdle: begin
                rdy = 1'b1;
                if (en) begin
                    state_d = StRdLen;
                end
            end
            StRdLen: begin
                ct_addr = '0;
                state_d = StWrLen;
            end
            StWrLen: begin
                pt_addr   = '0;
                pt_wrdata = ct_rddata;
                pt_wren   = 1'b1;
                len_d     = ct_rddata;
                i_d       = 8'd1;
                j_d       = '0;
                k_d       = 8'd1;
                state_d   = (ct_rddata == '0) ? StIdle : StRdSi;
            end
            StRdSi: begin
                s_addr  = i_q;
                state_d = StRdSj;
            end
            StRdSj: begin
                // s_rddata holds S[i] from the previous cycle's read
                si_d    = s_rddata;
                jn      = j_q + s_rddata;
                s_addr  = jn;
                j_d     = jn;
                state_d = StSwapI;
            end
            StSwapI: begin
                sj_d     = s_rddata;
                s_addr   = i_q;
                s_wrdata = s_rddata;
                s_wren   = 1'b1;
                state_d  = StSwapJ;
            end
            StSwapJ: begin
                s_addr   = j_q;
                s_wrdata = si_q;
                s_wren   = 1'b1;
                state_d  = StRdPad;
            end
            StRdPad: begin
                s_addr  = si_q + sj_q;
                ct_addr = k_q;
                state_d = StWrPt;
            end
            StWrPt: begin
                pt_addr   = k_q;
                pt_wrdata = s_rddata ^ ct_rddata;
                pt_wren   = 1'b1;
                if (k_q == len_q) begin
                    state_d = StIdle;
                end else begin
                    k_d     = k_q + 8'd1;
                    i_d     = i_q + 8'd1;
                    state_d = StRdSi;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            i_q     <= '0;
            j_q     <= '0;
            k_q     <= '0;
            len_q   <= '0;
            si_q    <= '0;
            sj_q    <= '0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            k_q     <= k_d;
            len_q   <= len_d;
            si_q    <= si_d;
            sj_q    <= sj_d;
        end
    end

endmodule
